// File: rtl/video_mode_ctrl.sv
// Applies video_mixer runtime config only at VSync boundaries, blanks whole frames
// around sync-type changes, and measures native line length / frame height.
module video_mode_ctrl #(
  parameter int unsigned MUTE_FRAMES = 2,
  parameter logic [23:0] VS_TIMEOUT  = 24'd4000000,
  parameter logic [9:0]  MIN_LINES   = 10'd200,
  parameter int          LEN_W       = 12
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic             HSync,
  input  logic             VSync,
  input  logic [1:0]       req_scanlines,
  input  logic             req_sd_disable,
  input  logic             req_hq2x,
  input  logic             req_ypbpr,
  input  logic             req_ypbpr_full,
  output logic [1:0]       scanlines,
  output logic             scandoubler_disable,
  output logic             hq2x,
  output logic             ypbpr,
  output logic             ypbpr_full,
  output logic             blank,
  output logic             mode_busy,
  output logic [LEN_W-1:0] line_len,
  output logic [9:0]       frame_lines,
  output logic             sync_ok
);

  typedef enum logic [1:0] {IDLE, PENDING, MUTE} state_t;

  localparam logic [7:0]  MUTE_INIT = 8'(MUTE_FRAMES);
  localparam logic [23:0] TMO_LAST  = VS_TIMEOUT - 24'd1;

  state_t      state, state_n;
  logic [5:0]  req_vec, app_vec, app_n;
  logic        blank_n;
  logic [7:0]  mute_cnt, mute_n;
  logic [23:0] tmo, tmo_n;
  logic        hs_q, vs_q;
  logic        hs_rise, vs_rise;
  logic        sync_change;

  logic [LEN_W-1:0] pix_cnt;
  logic [9:0]       line_cnt;
  logic [23:0]      vs_wd;

  assign hs_rise = HSync & ~hs_q;
  assign vs_rise = VSync & ~vs_q;

  // Bit layout: [5:4] scanlines, [3] sd_disable, [2] hq2x, [1] ypbpr, [0] ypbpr_full
  assign req_vec = {req_scanlines, req_sd_disable, req_hq2x, req_ypbpr, req_ypbpr_full};
  assign sync_change = (req_vec[3] != app_vec[3]) || (req_vec[1] != app_vec[1]);

  assign scanlines           = app_vec[5:4];
  assign scandoubler_disable = app_vec[3];
  assign hq2x                = app_vec[2];
  assign ypbpr               = app_vec[1];
  assign ypbpr_full          = app_vec[0];
  assign mode_busy           = (state != IDLE);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      app_vec  <= '0;
      blank    <= 1'b0;
      mute_cnt <= '0;
      tmo      <= '0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
    end else begin
      state    <= state_n;
      app_vec  <= app_n;
      blank    <= blank_n;
      mute_cnt <= mute_n;
      tmo      <= tmo_n;
      hs_q     <= HSync;
      vs_q     <= VSync;
    end
  end

  always_comb begin
    state_n = state;
    app_n   = app_vec;
    blank_n = blank;
    mute_n  = mute_cnt;
    tmo_n   = tmo;
    case (state)
      IDLE: begin
        if (req_vec != app_vec) begin
          state_n = PENDING;
          tmo_n   = '0;
        end
      end
      PENDING: begin
        tmo_n = tmo + 24'd1;
        if (req_vec == app_vec) begin
          state_n = IDLE;
        end else if (vs_rise || (tmo == TMO_LAST)) begin
          app_n = req_vec;
          // Mute countdown starts fresh; the apply edge itself is not a muted frame
          if (sync_change && (MUTE_FRAMES != 0)) begin
            blank_n = 1'b1;
            mute_n  = MUTE_INIT;
            tmo_n   = '0;
            state_n = MUTE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      MUTE: begin
        if (vs_rise) begin
          tmo_n  = '0;
          mute_n = mute_cnt - 8'd1;
          if (mute_cnt == 8'd1) begin
            blank_n = 1'b0;
            state_n = IDLE;
          end
        end else if (tmo == TMO_LAST) begin
          blank_n = 1'b0;
          state_n = IDLE;
        end else begin
          tmo_n = tmo + 24'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Native timing measurement runs independently of the mode FSM
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pix_cnt     <= '0;
      line_cnt    <= '0;
      vs_wd       <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      sync_ok     <= 1'b0;
    end else begin
      if (hs_rise) begin
        line_len <= pix_cnt;
        pix_cnt  <= {{(LEN_W-1){1'b0}}, ce_pix};
      end else if (ce_pix && (pix_cnt != '1)) begin
        pix_cnt <= pix_cnt + 1'b1;
      end

      if (vs_rise) begin
        frame_lines <= line_cnt;
        line_cnt    <= {9'd0, hs_rise};
        sync_ok     <= (line_cnt == frame_lines) && (line_cnt >= MIN_LINES) &&
                       (line_len != '0);
        vs_wd       <= '0;
      end else begin
        if (hs_rise && (line_cnt != 10'd1023))
          line_cnt <= line_cnt + 10'd1;
        if (vs_wd == TMO_LAST) begin
          sync_ok     <= 1'b0;
          frame_lines <= '0;
        end else begin
          vs_wd <= vs_wd + 24'd1;
        end
      end
    end
  end

endmodule
